// File: rtl/issue_scheduler_if.sv
// Fetch-side and decoder-side handshake bundle for issue_scheduler.
// The scheduler takes the slave view; the fetch/decode environment takes the master view.
interface issue_scheduler_if #(
  parameter int DAT_W = 32,
  parameter int ADR_W = 32
);
  logic             if_en_i;
  logic             if_ic_i;
  logic [DAT_W-1:0] if_ins_i;
  logic [ADR_W-1:0] if_pc_i;
  logic             if_pbr_i;
  logic             if_full_o;
  logic             dec_en_o;
  logic             dec_ic_o;
  logic [DAT_W-1:0] dec_ins_o;
  logic [ADR_W-1:0] dec_pc_o;
  logic             dec_pbr_o;

  modport master (
    output if_en_i, if_ic_i, if_ins_i, if_pc_i, if_pbr_i,
    input  if_full_o, dec_en_o, dec_ic_o, dec_ins_o, dec_pc_o, dec_pbr_o
  );

  modport slave (
    input  if_en_i, if_ic_i, if_ins_i, if_pc_i, if_pbr_i,
    output if_full_o, dec_en_o, dec_ic_o, dec_ins_o, dec_pc_o, dec_pbr_o
  );
endinterface

// File: rtl/issue_scheduler.sv
// In-order instruction queue between fetch and decode: issues at most one instruction per
// cycle when the ROB and the target station (RS or LSB) have room, and drops everything on flush.
module issue_scheduler #(
  parameter int IQ_DEPTH = 4,
  parameter int DAT_W    = 32,
  parameter int ADR_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush_i,
  input  logic             rob_full_i,
  input  logic             rs_full_i,
  input  logic             lsb_full_i,
  output logic [31:0]      stall_cnt_o,
  issue_scheduler_if.slave bus_io
);
  localparam int PW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;

  state_e           state_q;
  logic [PW-1:0]    rdPtr_q;
  logic [PW-1:0]    wrPtr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [31:0]      stallCnt_q;
  logic [31:0]      stallCnt_d;
  logic             decEn_q;
  logic             decIc_q;
  logic             decPbr_q;
  logic [DAT_W-1:0] decIns_q;
  logic [ADR_W-1:0] decPc_q;

  logic [DAT_W-1:0]    insMem [IQ_DEPTH];
  logic [ADR_W-1:0]    pcMem  [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] icMem;
  logic [IQ_DEPTH-1:0] pbrMem;

  logic headMem;
  logic canIssue;
  logic queueFull;
  logic pushEn;

  // Loads/stores (full or compressed) go to the LSB, everything else to the RS.
  always_comb begin
    if (icMem[rdPtr_q]) begin
      headMem = (insMem[rdPtr_q][1:0] == 2'b00 || insMem[rdPtr_q][1:0] == 2'b10) &&
                (insMem[rdPtr_q][15:13] == 3'b010 || insMem[rdPtr_q][15:13] == 3'b110);
    end else begin
      headMem = (insMem[rdPtr_q][6:0] == 7'b0000011) || (insMem[rdPtr_q][6:0] == 7'b0100011);
    end
    canIssue  = en && !flush_i && (state_q != FLUSH) && (count_q != '0) && !rob_full_i &&
                (headMem ? !lsb_full_i : !rs_full_i);
    queueFull = (count_q == CW'(IQ_DEPTH)) && !canIssue;
    pushEn    = en && bus_io.if_en_i && !flush_i && (state_q != FLUSH) && !queueFull;
    count_d   = count_q + CW'(pushEn) - CW'(canIssue);
    stallCnt_d = (stallCnt_q == '1) ? stallCnt_q : stallCnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (pushEn) begin
      insMem[wrPtr_q] <= bus_io.if_ins_i;
      pcMem[wrPtr_q]  <= bus_io.if_pc_i;
      icMem[wrPtr_q]  <= bus_io.if_ic_i;
      pbrMem[wrPtr_q] <= bus_io.if_pbr_i;
    end
  end

  // Flush outranks en=0, push and pop; en=0 freezes everything except the issue strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      count_q    <= '0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      stallCnt_q <= '0;
      decEn_q    <= 1'b0;
      decIc_q    <= 1'b0;
      decPbr_q   <= 1'b0;
      decIns_q   <= '0;
      decPc_q    <= '0;
    end else if (flush_i) begin
      state_q <= FLUSH;
      count_q <= '0;
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      decEn_q <= 1'b0;
    end else if (en) begin
      count_q <= count_d;
      decEn_q <= canIssue;
      if (pushEn) begin
        wrPtr_q <= wrPtr_q + PW'(1);
      end
      if (canIssue) begin
        rdPtr_q  <= rdPtr_q + PW'(1);
        decIns_q <= insMem[rdPtr_q];
        decPc_q  <= pcMem[rdPtr_q];
        decIc_q  <= icMem[rdPtr_q];
        decPbr_q <= pbrMem[rdPtr_q];
      end
      case (state_q)
        RUN: begin
          if (count_q != '0 && !canIssue) begin
            state_q <= STALL;
          end
        end
        STALL: begin
          stallCnt_q <= stallCnt_d;
          if (canIssue) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end else begin
      decEn_q <= 1'b0;
    end
  end

  assign bus_io.if_full_o = queueFull;
  assign bus_io.dec_en_o  = decEn_q;
  assign bus_io.dec_ic_o  = decIc_q;
  assign bus_io.dec_ins_o = decIns_q;
  assign bus_io.dec_pc_o  = decPc_q;
  assign bus_io.dec_pbr_o = decPbr_q;
  assign stall_cnt_o      = stallCnt_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: a per-cycle vector table plus hand-written
// multi-cycle sequences, with issued instruction data checked through an in-order scoreboard.
module tb_issue_scheduler;
  typedef struct {
    logic        ifEn;
    logic        ic;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        pbr;
    logic        robFull;
    logic        rsFull;
    logic        lsbFull;
    logic        flush;
    logic        enIn;
    logic        rstN;
    logic        accept;
    logic        expFull;
    logic        expDecEn;
    logic        chkStall;
    logic [31:0] expStall;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        ic;
    logic        pbr;
  } exp_t;

  localparam logic [31:0] ADDI  = 32'h0050_0093;
  localparam logic [31:0] LW    = 32'h0000_a103;
  localparam logic [31:0] CSW   = 32'h0000_c04c;
  localparam logic [31:0] CADDI = 32'h0000_0505;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        flushIn;
  logic        robFull;
  logic        rsFull;
  logic        lsbFull;
  logic [31:0] stallCnt;

  int   total = 0;
  int   bad = 0;
  exp_t expQ[$];
  vec_t vecTab[$];
  vec_t v;

  always #5 clk = ~clk;

  issue_scheduler_if #(.DAT_W(32), .ADR_W(32)) bus ();

  issue_scheduler #(.IQ_DEPTH(4), .DAT_W(32), .ADR_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .flush_i(flushIn),
    .rob_full_i(robFull),
    .rs_full_i(rsFull),
    .lsb_full_i(lsbFull),
    .stall_cnt_o(stallCnt),
    .bus_io(bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, want);
    end
  endtask

  function automatic vec_t mk(input logic ifEn, input logic ic, input logic [31:0] ins,
                              input logic [31:0] pc, input logic robF, input logic rsF,
                              input logic lsbF, input logic enIn, input logic accept,
                              input logic expDec, input logic [31:0] expStall);
    vec_t r;
    r.ifEn = ifEn;      r.ic = ic;          r.ins = ins;       r.pc = pc;
    r.pbr = pc[2];      r.robFull = robF;   r.rsFull = rsF;    r.lsbFull = lsbF;
    r.flush = 1'b0;     r.enIn = enIn;      r.rstN = 1'b1;     r.accept = accept;
    r.expFull = 1'b0;   r.expDecEn = expDec; r.chkStall = 1'b1; r.expStall = expStall;
    return r;
  endfunction

  // One clock: drive inputs, check the combinational full flag, clock, then check registered outputs.
  task automatic applyStimulus(input vec_t s, input string tag);
    exp_t e;
    rst = s.rstN;          en = s.enIn;          flushIn = s.flush;
    robFull = s.robFull;   rsFull = s.rsFull;    lsbFull = s.lsbFull;
    bus.if_en_i = s.ifEn;  bus.if_ic_i = s.ic;   bus.if_ins_i = s.ins;
    bus.if_pc_i = s.pc;    bus.if_pbr_i = s.pbr;
    #1;
    checkOutput({tag, " if_full_o"}, 32'(bus.if_full_o), 32'(s.expFull));
    if (s.accept) begin
      e.ins = s.ins; e.pc = s.pc; e.ic = s.ic; e.pbr = s.pbr;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    checkOutput({tag, " dec_en_o"}, 32'(bus.dec_en_o), 32'(s.expDecEn));
    if (s.chkStall) checkOutput({tag, " stall_cnt_o"}, stallCnt, s.expStall);
    if (bus.dec_en_o === 1'b1) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL %s scoreboard: got issue of pc 0x%08h want no issue", tag, bus.dec_pc_o);
      end else begin
        e = expQ.pop_front();
        checkOutput({tag, " dec_pc_o"}, bus.dec_pc_o, e.pc);
        checkOutput({tag, " dec_ins_o"}, bus.dec_ins_o, e.ins);
        checkOutput({tag, " dec_ic_o"}, 32'(bus.dec_ic_o), 32'(e.ic));
        checkOutput({tag, " dec_pbr_o"}, 32'(bus.dec_pbr_o), 32'(e.pbr));
      end
    end
  endtask

  initial begin
    // ifEn ic ins pc | rob rs lsb en | accept expDec expStall
    vecTab.push_back(mk(1, 0, ADDI,  32'h00, 0, 0, 0, 1, 1, 0, 0));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 0, 0, 1, 0, 1, 0));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 0, 0, 1, 0, 0, 0));
    vecTab.push_back(mk(1, 0, LW,    32'h04, 0, 0, 1, 1, 1, 0, 0));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 0, 1, 1, 0, 0, 0));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 0, 1, 1, 0, 0, 1));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 0, 1, 1, 0, 0, 2));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 1, 0, 1, 0, 1, 3));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 1, 0, 1, 0, 0, 3));
    vecTab.push_back(mk(1, 1, CSW,   32'h08, 0, 0, 1, 1, 1, 0, 3));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 0, 1, 1, 0, 0, 3));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 0, 1, 1, 0, 0, 4));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 1, 0, 1, 0, 1, 5));
    vecTab.push_back(mk(1, 1, CADDI, 32'h0a, 0, 1, 0, 1, 1, 0, 5));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 1, 0, 1, 0, 0, 5));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 1, 0, 1, 0, 0, 6));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 0, 1, 1, 0, 1, 7));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 0, 0, 1, 0, 0, 7));
    vecTab.push_back(mk(1, 0, ADDI,  32'h10, 0, 0, 0, 0, 0, 0, 7));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 0, 0, 1, 0, 0, 7));
    vecTab.push_back(mk(1, 0, ADDI,  32'h14, 1, 0, 0, 1, 1, 0, 7));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 1, 0, 0, 1, 0, 0, 7));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 1, 0, 0, 0, 0, 0, 7));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 1, 0, 0, 1, 0, 0, 8));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 0, 0, 1, 0, 1, 9));
    vecTab.push_back(mk(0, 0, 0,     32'h00, 0, 0, 0, 1, 0, 0, 9));

    rst = 1'b0; en = 1'b1; flushIn = 1'b0; robFull = 1'b0; rsFull = 1'b0; lsbFull = 1'b0;
    bus.if_en_i = 1'b0; bus.if_ic_i = 1'b0; bus.if_ins_i = '0; bus.if_pc_i = '0; bus.if_pbr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    v = mk(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 0);
    v.rstN = 1'b0;
    applyStimulus(v, "reset");
    checkOutput("reset dec_pc_o", bus.dec_pc_o, 32'h0);
    checkOutput("reset dec_ins_o", bus.dec_ins_o, 32'h0);
    checkOutput("reset dec_ic_o", 32'(bus.dec_ic_o), 32'h0);

    foreach (vecTab[i]) applyStimulus(vecTab[i], $sformatf("vec%0d", i));

    // Reset while stalled loses the queued entry and clears the stall counter.
    applyStimulus(mk(1, 0, ADDI, 32'h20, 1, 0, 0, 1, 1, 0, 9), "rststall push");
    applyStimulus(mk(0, 0, 0, 32'h0, 1, 0, 0, 1, 0, 0, 9), "rststall enter");
    applyStimulus(mk(0, 0, 0, 32'h0, 1, 0, 0, 1, 0, 0, 10), "rststall count");
    expQ.delete();
    v = mk(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 0);
    v.rstN = 1'b0;
    applyStimulus(v, "rststall reset");
    applyStimulus(mk(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 0), "rststall after");

    // Fill past capacity with the ROB full: fifth push is refused, then four back-to-back issues.
    for (int i = 0; i < 5; i++) begin
      v = mk(1, 0, 32'h0000_0013 | (i << 7), 32'h40 + 4 * i, 1, 0, 0, 1, i < 4, 0, 0);
      v.expFull = (i == 4);
      v.chkStall = 1'b0;
      applyStimulus(v, $sformatf("fill%0d", i));
    end
    for (int i = 0; i < 5; i++) begin
      v = mk(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, i < 4, 0);
      v.chkStall = 1'b0;
      applyStimulus(v, $sformatf("drain%0d", i));
    end

    // Full queue with push and pop on the same edge, running the pointers across the wrap.
    for (int i = 0; i < 4; i++) begin
      v = mk(1, 0, 32'h0000_0033 | (i << 7), 32'h80 + 4 * i, 1, 0, 0, 1, 1, 0, 0);
      v.chkStall = 1'b0;
      applyStimulus(v, $sformatf("wrapfill%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      v = mk(1, 0, 32'h0000_00b3 | (i << 7), 32'h90 + 4 * i, 0, 0, 0, 1, 1, 1, 0);
      v.chkStall = 1'b0;
      applyStimulus(v, $sformatf("wrapboth%0d", i));
    end
    for (int i = 0; i < 5; i++) begin
      v = mk(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, i < 4, 0);
      v.chkStall = 1'b0;
      applyStimulus(v, $sformatf("wrapdrain%0d", i));
    end

    // Flush with three queued and fetch still presenting: nothing issues, the stale push is ignored.
    for (int i = 0; i < 3; i++) begin
      v = mk(1, 0, ADDI, 32'hc0 + 4 * i, 1, 0, 0, 1, 1, 0, 0);
      v.chkStall = 1'b0;
      applyStimulus(v, $sformatf("flushfill%0d", i));
    end
    expQ.delete();
    v = mk(1, 0, ADDI, 32'hd0, 0, 0, 0, 1, 0, 0, 0);
    v.flush = 1'b1;
    v.chkStall = 1'b0;
    applyStimulus(v, "flush edge");
    v = mk(1, 0, ADDI, 32'hd4, 0, 0, 0, 1, 0, 0, 0);
    v.chkStall = 1'b0;
    applyStimulus(v, "flush stale");
    v = mk(1, 0, ADDI, 32'hd8, 0, 0, 0, 1, 1, 0, 0);
    v.chkStall = 1'b0;
    applyStimulus(v, "flush push");
    v = mk(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 1, 0);
    v.chkStall = 1'b0;
    applyStimulus(v, "flush issue");
    v = mk(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 0);
    v.chkStall = 1'b0;
    applyStimulus(v, "flush idle");

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
